// File: rtl/seg7_scan_display_ctrl_pkg.sv
// Shared types and glyph constants for the multiplexed 7-segment scan driver.
package seg7_scan_display_ctrl_pkg;
    localparam int MAX_DATA_W  = 8;
    localparam int GLYPH_COUNT = 20;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ERR   = 7'h7F;

    // One digit slot; code is zero-extended to the widest supported code.
    typedef struct packed {
        logic                  vld;
        logic                  perr;
        logic [MAX_DATA_W-1:0] code;
    } digit_t;
endpackage

// File: rtl/seg7_scan_display_ctrl_if.sv
// Write/commit/error bus between the parity-protected source and the scan driver.
interface seg7_scan_display_ctrl_if #(
    parameter int N_DIGITS = 4,
    parameter int DATA_W   = 5
);
    localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_code;
    logic              wr_par;
    logic              commit;
    logic              commit_pending;
    logic              err_clr;
    logic              par_err_sticky;

    modport master (
        output wr_en, wr_addr, wr_code, wr_par, commit, err_clr,
        input  commit_pending, par_err_sticky
    );
    modport slave (
        input  wr_en, wr_addr, wr_code, wr_par, commit, err_clr,
        output commit_pending, par_err_sticky
    );
endinterface

// File: rtl/seg7_scan_display_ctrl_glyph_rom.sv
// Code -> {A..G} segment pattern; codes past the glyph table show blank.
module seg7_scan_display_ctrl_glyph_rom
    import seg7_scan_display_ctrl_pkg::*;
(
    input  logic [MAX_DATA_W-1:0] code,
    output logic [6:0]            glyph
);
    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            8'd0:  glyph = 7'h7E;
            8'd1:  glyph = 7'h30;
            8'd2:  glyph = 7'h6D;
            8'd3:  glyph = 7'h79;
            8'd4:  glyph = 7'h33;
            8'd5:  glyph = 7'h5B;
            8'd6:  glyph = 7'h5F;
            8'd7:  glyph = 7'h70;
            8'd8:  glyph = 7'h7F;
            8'd9:  glyph = 7'h7B;
            8'd10: glyph = 7'h77;
            8'd11: glyph = 7'h1F;
            8'd12: glyph = 7'h4E;
            8'd13: glyph = 7'h3D;
            8'd14: glyph = 7'h4F;
            8'd15: glyph = 7'h47;
            8'd16: glyph = 7'h37;
            8'd17: glyph = 7'h0E;
            8'd18: glyph = 7'h67;
            8'd19: glyph = 7'h3E;
            default: glyph = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_display_ctrl.sv
// N-digit scan driver: parity-checked shadow bank, tear-free commit at the frame
// boundary, one digit per slot with an anti-ghost blank at slot start.
module seg7_scan_display_ctrl
    import seg7_scan_display_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DATA_W       = 5,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    seg7_scan_display_ctrl_if.slave bus,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] dig_n,
    output logic                frame_start
);
    localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = $clog2(PRESCALE);

    logic [CW-1:0]       cnt;
    logic [AW-1:0]       idx;
    digit_t              shadow [N_DIGITS];
    digit_t              active [N_DIGITS];
    digit_t              wr_ent, sel;
    logic                parity_ok, wr_hit, last_slot, copy_now;
    logic [6:0]          rom_glyph, seg_nxt;
    logic [N_DIGITS-1:0] dig_nxt;

    assign parity_ok = ((^bus.wr_code) ^ bus.wr_par) == 1'(PARITY_ODD);
    assign wr_hit    = bus.wr_en && (int'(bus.wr_addr) < N_DIGITS);
    assign wr_ent    = '{vld: 1'b1, perr: ~parity_ok, code: MAX_DATA_W'(bus.wr_code)};
    assign last_slot = (int'(idx) == N_DIGITS-1) && (int'(cnt) == PRESCALE-1);
    // Dark display has no frame to tear, so a disabled scan copies immediately.
    assign copy_now  = bus.commit_pending && (!enable || last_slot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (wr_hit && int'(bus.wr_addr) == i)
                    shadow[i] <= wr_ent;
                // A write landing on the copy edge bypasses into the new frame.
                if (copy_now)
                    active[i] <= (wr_hit && int'(bus.wr_addr) == i) ? wr_ent : shadow[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.commit_pending <= 1'b0;
            bus.par_err_sticky <= 1'b0;
        end else begin
            if (copy_now)        bus.commit_pending <= bus.commit;
            else if (bus.commit) bus.commit_pending <= 1'b1;
            if (wr_hit && !parity_ok) bus.par_err_sticky <= 1'b1;
            else if (bus.err_clr)     bus.par_err_sticky <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (int'(cnt) == PRESCALE-1) begin
            cnt <= '0;
            idx <= (int'(idx) == N_DIGITS-1) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sel = active[idx];

    seg7_scan_display_ctrl_glyph_rom u_rom (
        .code  (sel.code),
        .glyph (rom_glyph)
    );

    always_comb begin
        seg_nxt = SEG_BLANK;
        dig_nxt = '1;
        if (enable && int'(cnt) >= BLANK_CYCLES) begin
            dig_nxt[idx] = 1'b0;
            if (!sel.vld)      seg_nxt = SEG_BLANK;
            else if (sel.perr) seg_nxt = SEG_ERR;
            else               seg_nxt = rom_glyph;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= '0;
            dig_n       <= '1;
            frame_start <= 1'b0;
        end else begin
            seg         <= seg_nxt;
            dig_n       <= dig_nxt;
            frame_start <= enable && cnt == '0 && idx == '0;
        end
    end
endmodule
